// File: rtl/tri_pkg.sv
// Shared types and helpers for the triangle stream FIFO.
// A triangle is COORDS x VERTS words; word [c][v] sits at bit offset
// (c*VERTS + v)*WORD_W of the flat vector, which is also the natural
// layout of the packed [COORDS][VERTS][WORD_W] array.
package tri_pkg;

    localparam int TRI_WORD_W = 32;
    localparam int TRI_COORDS = 4;
    localparam int TRI_VERTS  = 3;
    localparam int TRI_W      = TRI_WORD_W * TRI_COORDS * TRI_VERTS;
    // Triangle bits plus the end-of-object marker in the top bit.
    localparam int ENTRY_W    = TRI_W + 1;

    typedef logic [TRI_COORDS-1:0][TRI_VERTS-1:0][TRI_WORD_W-1:0] tri_t;

    // Flatten a triangle into a plain bit vector.
    function automatic logic [TRI_W-1:0] pack_tri(input tri_t t);
        logic [TRI_W-1:0] r;
        r = '0;
        for (int c = 0; c < TRI_COORDS; c++) begin
            for (int v = 0; v < TRI_VERTS; v++) begin
                r[(c*TRI_VERTS + v)*TRI_WORD_W +: TRI_WORD_W] = t[c][v];
            end
        end
        return r;
    endfunction

    // Rebuild a triangle from its flat bit vector.
    function automatic tri_t unpack_tri(input logic [TRI_W-1:0] r);
        tri_t t;
        t = '0;
        for (int c = 0; c < TRI_COORDS; c++) begin
            for (int v = 0; v < TRI_VERTS; v++) begin
                t[c][v] = r[(c*TRI_VERTS + v)*TRI_WORD_W +: TRI_WORD_W];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/tri_fifo_mem.sv
// Simple dual-port storage for the triangle FIFO: one synchronous write
// port and one asynchronous read port, so it maps onto distributed RAM.
// Contents are never cleared; the control logic tracks what is valid.
module tri_fifo_mem
    import tri_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one entry per accepted push.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Fall-through read of the addressed entry.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/tri_stream_fifo.sv
// Triangle FIFO between the vertex/transform stage and the projector.
// One entry holds a whole triangle plus an end-of-object marker. Besides
// occupancy it tracks how many complete objects (entries with last=1) are
// resident, so the projector can wait until a whole object is buffered.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. s_ready_out depends only on the registered count (never on
// m_ready_in), m_valid_out depends only on the registered count, and the
// sender must hold its payload stable while valid is high and ready is low.
// Nothing transfers on a cycle with rst_in or flush_in asserted.
module tri_stream_fifo
    import tri_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int COORDS   = 4,
    parameter int VERTS    = 3,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   flush_in,
    input  logic                                   s_valid_in,
    output logic                                   s_ready_out,
    input  logic [COORDS-1:0][VERTS-1:0][WORD_W-1:0] s_tri_in,
    input  logic                                   s_last_in,
    output logic                                   m_valid_out,
    input  logic                                   m_ready_in,
    output logic [COORDS-1:0][VERTS-1:0][WORD_W-1:0] m_tri_out,
    output logic                                   m_last_out,
    output logic [CNT_W-1:0]                       count_out,
    output logic [CNT_W-1:0]                       obj_count_out,
    output logic                                   almost_full_out
);

    localparam int FLAT_W = COORDS * VERTS * WORD_W;
    localparam int E_W    = FLAT_W + 1;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] obj_count_q;

    logic [E_W-1:0]   wr_entry;
    logic [E_W-1:0]   rd_entry;
    logic             rd_last;
    logic             hold;
    logic             push;
    logic             pop;
    logic             push_last;
    logic             pop_last;

    // Status comes straight from the registered count; full/empty are
    // never inferred from pointer equality.
    assign s_ready_out     = (count_q != CNT_FULL);
    assign m_valid_out     = (count_q != '0);
    assign almost_full_out = (count_q >= CNT_AF);
    assign count_out       = count_q;
    assign obj_count_out   = obj_count_q;

    // Reset and flush both discard the contents and block any handshake.
    assign hold      = rst_in || flush_in;
    assign push      = s_valid_in && s_ready_out && !hold;
    assign pop       = m_valid_out && m_ready_in && !hold;
    assign push_last = push && s_last_in;
    assign pop_last  = pop && rd_last;

    // Entry layout: marker in the top bit, flattened triangle below it.
    assign wr_entry = {s_last_in, s_tri_in};

    tri_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (E_W)
    ) u_mem (
        .clk_in  (clk_in),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    assign rd_last = rd_entry[E_W-1];

    // The head payload is whatever sits at rd_ptr; the marker is forced low
    // while empty so stale memory never shows up as an object boundary.
    assign m_tri_out  = rd_entry[FLAT_W-1:0];
    assign m_last_out = m_valid_out && rd_last;

    // Pointers advance per handshake and wrap naturally at DEPTH.
    always_ff @(posedge clk_in) begin
        if (hold) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Entry count: up on push only, down on pop only, else unchanged.
    always_ff @(posedge clk_in) begin
        if (hold) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Complete-object count follows the marker of pushed and popped entries.
    always_ff @(posedge clk_in) begin
        if (hold) begin
            obj_count_q <= '0;
        end else begin
            case ({push_last, pop_last})
                2'b10:   obj_count_q <= obj_count_q + CNT_ONE;
                2'b01:   obj_count_q <= obj_count_q - CNT_ONE;
                default: obj_count_q <= obj_count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_stream_fifo.sv
// Bench for tri_stream_fifo: directed scenarios with hand-computed
// expectations, plus a negedge monitor that keeps an expected queue of
// accepted entries and compares the head and all flags every cycle.
module tb_tri_stream_fifo;

    localparam int WORD_W = 32;
    localparam int COORDS = 4;
    localparam int VERTS  = 3;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;
    localparam int TRI_W  = WORD_W * COORDS * VERTS;

    typedef logic [COORDS-1:0][VERTS-1:0][WORD_W-1:0] tri_vec_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    tri_vec_t         s_tri;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    tri_vec_t         m_tri;
    logic             m_last;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] obj_count;
    logic             almost_full;

    tri_stream_fifo #(
        .WORD_W   (WORD_W),
        .COORDS   (COORDS),
        .VERTS    (VERTS),
        .DEPTH    (DEPTH),
        .AF_LEVEL (DEPTH - 2)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .flush_in        (flush),
        .s_valid_in      (s_valid),
        .s_ready_out     (s_ready),
        .s_tri_in        (s_tri),
        .s_last_in       (s_last),
        .m_valid_out     (m_valid),
        .m_ready_in      (m_ready),
        .m_tri_out       (m_tri),
        .m_last_out      (m_last),
        .count_out       (count),
        .obj_count_out   (obj_count),
        .almost_full_out (almost_full)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks = 0;
    int  passes = 0;
    bit  mon_en = 1'b0;
    logic [TRI_W:0] exp_q[$];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic tri_vec_t fill_tri(input logic [31:0] w);
        tri_vec_t t;
        for (int c = 0; c < COORDS; c++)
            for (int v = 0; v < VERTS; v++)
                t[c][v] = w;
        return t;
    endfunction

    function automatic tri_vec_t rand_tri();
        tri_vec_t t;
        for (int c = 0; c < COORDS; c++)
            for (int v = 0; v < VERTS; v++)
                t[c][v] = $urandom;
        return t;
    endfunction

    // Advance one edge; inputs may change right after it returns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] w, input logic last);
        s_valid = 1'b1;
        s_tri   = fill_tri(w);
        s_last  = last;
        tick();
        s_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    // Compares outputs against the expected queue, then applies the edge
    // that is about to happen to the queue.
    always @(negedge clk) begin : monitor
        int sz;
        int lasts;
        if (mon_en) begin
            sz    = exp_q.size();
            lasts = 0;
            foreach (exp_q[i]) lasts += int'(exp_q[i][TRI_W]);
            chk("mon_count",       64'(count),       64'(sz));
            chk("mon_obj_count",   64'(obj_count),   64'(lasts));
            chk("mon_m_valid",     64'(m_valid),     64'(sz != 0));
            chk("mon_s_ready",     64'(s_ready),     64'(sz != DEPTH));
            chk("mon_almost_full", 64'(almost_full), 64'(sz >= DEPTH - 2));
            if (sz != 0) begin
                checks++;
                if ({m_last, m_tri} === exp_q[0]) passes++;
                else $display("FAIL mon_head: got %0h expected %0h at %0t", {m_last, m_tri}, exp_q[0], $time);
            end
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (sz != 0 && m_ready) void'(exp_q.pop_front());
                if (s_valid && sz != DEPTH) exp_q.push_back({s_last, s_tri});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_tri   = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("rst_count",       64'(count),       64'd0);
        chk("rst_obj_count",   64'(obj_count),   64'd0);
        chk("rst_m_valid",     64'(m_valid),     64'd0);
        chk("rst_s_ready",     64'(s_ready),     64'd1);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_m_last",      64'(m_last),      64'd0);

        // Single push of 1.0f words, head held while not ready
        push_one(32'h3F80_0000, 1'b1);
        s_tri = fill_tri(32'h0);
        for (int k = 0; k < 5; k++) begin
            chk("single_count",   64'(count),     64'd1);
            chk("single_obj",     64'(obj_count), 64'd1);
            chk("single_m_valid", 64'(m_valid),   64'd1);
            chk("single_m_last",  64'(m_last),    64'd1);
            chk("single_hold",    64'(m_tri[k % COORDS][k % VERTS]), 64'h3F80_0000);
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("single_drained", 64'(count), 64'd0);

        // Fill to full with 17 offers; the last one must be refused
        for (int i = 0; i < 17; i++) begin
            int exp_cnt;
            s_valid = 1'b1;
            s_tri   = fill_tri(32'(i));
            s_last  = (i % 4 == 3);
            tick();
            exp_cnt = (i + 1 > DEPTH) ? DEPTH : i + 1;
            chk("fill_count",       64'(count),       64'(exp_cnt));
            chk("fill_almost_full", 64'(almost_full), 64'(exp_cnt >= 14));
            chk("fill_s_ready",     64'(s_ready),     64'(exp_cnt != DEPTH));
        end
        s_valid = 1'b0;
        chk("fill_obj", 64'(obj_count), 64'd4);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_word", 64'(m_tri[2][1]), 64'(i));
            chk("drain_last", 64'(m_last),      64'(i % 4 == 3));
            tick();
        end
        m_ready = 1'b0;
        chk("drain_empty", 64'(count), 64'd0);

        // Simultaneous push and pop at count 8, crossing the pointer wrap
        for (int i = 0; i < 8; i++) push_one(32'(100 + i), i == 7);
        chk("sim_pre_count", 64'(count), 64'd8);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            chk("sim_head", 64'(m_tri[1][2]), 64'(j < 8 ? 100 + j : 200 + j - 8));
            s_tri  = fill_tri(32'(200 + j));
            s_last = j[0];
            tick();
            chk("sim_count", 64'(count), 64'd8);
        end
        s_valid = 1'b0;
        repeat (8) tick();
        m_ready = 1'b0;
        chk("sim_drained", 64'(count), 64'd0);

        // Push and pop together while empty: only the push happens
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_tri   = fill_tri(32'hA5A5_0001);
        s_last  = 1'b0;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("empty_pp_count",   64'(count),       64'd1);
        chk("empty_pp_m_valid", 64'(m_valid),     64'd1);
        chk("empty_pp_word",    64'(m_tri[3][0]), 64'hA5A5_0001);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Flush with a concurrent push at count 10 holding 3 objects
        for (int i = 0; i < 10; i++) push_one(32'(300 + i), i == 2 || i == 5 || i == 9);
        chk("flush_pre_count", 64'(count),     64'd10);
        chk("flush_pre_obj",   64'(obj_count), 64'd3);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_tri   = fill_tri(32'hDEAD_BEEF);
        s_last  = 1'b1;
        chk("flush_s_ready", 64'(s_ready), 64'd1);
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("flush_count",   64'(count),     64'd0);
        chk("flush_obj",     64'(obj_count), 64'd0);
        chk("flush_m_valid", 64'(m_valid),   64'd0);
        push_one(32'h0000_600D, 1'b0);
        chk("post_flush_word", 64'(m_tri[0][0]), 64'h0000_600D);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Random valid/ready soak with occasional flush and one reset
        for (int n = 0; n < 3000; n++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_tri   = rand_tri();
            s_last  = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 199) == 0);
            rst     = (n == 1500);
            tick();
            if (n == 1500) begin
                rst = 1'b0;
                chk("midrst_count",       64'(count),       64'd0);
                chk("midrst_obj_count",   64'(obj_count),   64'd0);
                chk("midrst_m_valid",     64'(m_valid),     64'd0);
                chk("midrst_s_ready",     64'(s_ready),     64'd1);
                chk("midrst_almost_full", 64'(almost_full), 64'd0);
                chk("midrst_m_last",      64'(m_last),      64'd0);
            end
        end
        s_valid = 1'b0;
        flush   = 1'b0;
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        chk("final_count", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
